// File: rtl/sram_sample_ring.sv
// Ring-buffer manager for 16-bit audio samples held in external SRAM.
// Arbitrates capture writes against delayed-tap reads, one bridge transaction at a time.
module sram_sample_ring #(
  parameter int unsigned BASE_WORD   = 0,
  parameter int unsigned DEPTH_LOG2  = 16,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [15:0]           wr_sample,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DEPTH_LOG2-1:0] rd_delay,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  output logic [15:0]           rd_data,
  output logic                  rd_data_valid,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  rd_underfill,
  output logic                  timeout_err,
  output logic [20:0]           bridge_address,
  output logic [1:0]            bridge_byte_enable,
  output logic                  bridge_read,
  output logic                  bridge_write,
  output logic [15:0]           bridge_write_data,
  input  logic                  bridge_acknowledge,
  input  logic [15:0]           bridge_read_data
);

  localparam int unsigned          CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [19:0]          BASE_W   = 20'(BASE_WORD);
  localparam logic [DEPTH_LOG2:0]  FILL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Ring offset to bridge byte address (the bridge addresses bytes, the ring counts words).
  function automatic logic [20:0] ring_byte_addr(input logic [DEPTH_LOG2-1:0] off);
    logic [19:0] word;
    word = BASE_W + 20'(off);
    return {word, 1'b0};
  endfunction

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic                  last_wr_q, last_wr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [20:0]           addr_q, addr_d;
  logic [15:0]           rd_data_q, rd_data_d;
  logic                  rdv_q, rdv_d;
  logic                  underfill_q, underfill_d;
  logic                  tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                  brd_q, brd_d;
  logic                  bwr_q, bwr_d;

  logic                  is_idle;
  logic                  grant_wr;
  logic                  grant_rd;
  logic [DEPTH_LOG2-1:0] rd_off;
  logic                  underfill_hit;

  // A pending read only beats a pending write when the previous grant went to the writer.
  assign is_idle       = (state_q == S_IDLE);
  assign grant_wr      = is_idle && wr_valid && !(rd_valid && last_wr_q);
  assign grant_rd      = is_idle && rd_valid && !grant_wr;
  assign rd_off        = wr_ptr_q - DEPTH_LOG2'(1) - rd_delay;
  assign underfill_hit = ({1'b0, rd_delay} >= fill_q);

  // Next-state and registered-output computation for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    last_wr_d   = last_wr_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    rd_data_d   = rd_data_q;
    rdv_d       = 1'b0;
    underfill_d = 1'b0;
    tmo_err_d   = 1'b0;
    tmo_cnt_d   = tmo_cnt_q;
    brd_d       = brd_q;
    bwr_d       = bwr_q;
    case (state_q)
      S_IDLE: begin
        if (grant_wr) begin
          wdata_d   = wr_sample;
          addr_d    = ring_byte_addr(wr_ptr_q);
          bwr_d     = 1'b1;
          last_wr_d = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_WRITE;
        end else if (grant_rd) begin
          last_wr_d = 1'b0;
          if (underfill_hit) begin
            rd_data_d   = 16'h0000;
            rdv_d       = 1'b1;
            underfill_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            addr_d    = ring_byte_addr(rd_off);
            brd_d     = 1'b1;
            tmo_cnt_d = '0;
            state_d   = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (bridge_acknowledge) begin
          bwr_d    = 1'b0;
          wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
          if (fill_q != FILL_MAX) begin
            fill_d = fill_q + (DEPTH_LOG2 + 1)'(1);
          end else begin
            fill_d = fill_q;
          end
          state_d = S_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          bwr_d     = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      S_READ: begin
        if (bridge_acknowledge) begin
          brd_d     = 1'b0;
          rd_data_d = bridge_read_data;
          rdv_d     = 1'b1;
          state_d   = S_RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // The tap engine always gets an answer, even when the SRAM stays silent.
          brd_d     = 1'b0;
          rd_data_d = 16'h0000;
          rdv_d     = 1'b1;
          tmo_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        brd_d   = 1'b0;
        bwr_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      last_wr_q   <= 1'b0;
      wdata_q     <= 16'h0000;
      addr_q      <= 21'h000000;
      rd_data_q   <= 16'h0000;
      rdv_q       <= 1'b0;
      underfill_q <= 1'b0;
      tmo_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      brd_q       <= 1'b0;
      bwr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      last_wr_q   <= last_wr_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      rd_data_q   <= rd_data_d;
      rdv_q       <= rdv_d;
      underfill_q <= underfill_d;
      tmo_err_q   <= tmo_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
      brd_q       <= brd_d;
      bwr_q       <= bwr_d;
    end
  end

  assign wr_ready           = grant_wr;
  assign rd_ready           = grant_rd;
  assign rd_data            = rd_data_q;
  assign rd_data_valid      = rdv_q;
  assign fill_level         = fill_q;
  assign rd_underfill       = underfill_q;
  assign timeout_err        = tmo_err_q;
  assign bridge_address     = addr_q;
  assign bridge_byte_enable = (brd_q || bwr_q) ? 2'b11 : 2'b00;
  assign bridge_read        = brd_q;
  assign bridge_write       = bwr_q;
  assign bridge_write_data  = wdata_q;

endmodule
